// File: rtl/uart_pkg.sv
// Shared types and constants for the auto-baud word receiver.
package uart_pkg;

  typedef enum logic {
    CAL_IDLE,
    CAL_MEAS
  } cal_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // The host opens every session with this byte; only its start bit is low.
  localparam logic [7:0]  SYNC_BYTE = 8'hFF;
  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_autobaud_meter.sv
// rx synchroniser, edge detect and bit-period measurement from the sync byte.
module uart_autobaud_meter
#(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned MIN_DIV = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             rx_i,
  input  logic             rearm_i,
  output logic             rxs_o,
  output logic             fall_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] div_o
);
  import uart_pkg::*;

  logic             meta_q, rxs_q, prev_q;
  logic             rise;
  cal_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             locked_q, locked_d;

  assign rise     = ~prev_q & rxs_q;
  assign fall_o   = prev_q & ~rxs_q;
  assign rxs_o    = rxs_q;
  assign locked_o = locked_q;
  assign div_o    = div_q;

  // Two-flop synchroniser plus one delayed copy for edge detection; idles high.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      rxs_q  <= meta_q;
      prev_q <= rxs_q;
    end
  end

  // Calibration state and measurement registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= CAL_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      locked_q <= locked_d;
    end
  end

  // Measure the low time of the sync start bit; reject glitches and overflow.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    locked_d = locked_q;
    if (rearm_i) begin
      state_d  = CAL_IDLE;
      cnt_d    = '0;
      div_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        CAL_IDLE: begin
          if (!locked_q && fall_o) begin
            cnt_d   = '0;
            state_d = CAL_MEAS;
          end
        end
        CAL_MEAS: begin
          if (rise) begin
            // A saturated count means the low outlasted the counter range.
            if ((cnt_q != '1) && (cnt_q >= CNT_W'(MIN_DIV))) begin
              div_d    = cnt_q;
              locked_d = 1'b1;
            end
            state_d = CAL_IDLE;
          end else if (!rxs_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = CAL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_autobaud_word_rx.sv
// 8N1 receiver on the measured bit period; packs bytes MSB-first into words
// presented on a valid/ready handshake with framing, overrun and timeout pulses.
module uart_autobaud_word_rx
#(
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned MIN_DIV      = 16,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  input  logic                    rearm,
  output logic                    baud_locked,
  output logic [CNT_W-1:0]        baud_div,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    frame_err,
  output logic                    overrun_err,
  output logic                    timeout_err
);
  import uart_pkg::*;

  localparam int unsigned WORD_W = DATA_BITS * WORD_BYTES;
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned LIM_W  = CNT_W + 6;
  localparam int unsigned PROD_W = 2 * LIM_W;

  logic                 rxs, rxs_fall;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     tmr_q, tmr_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]    asm_q, asm_d;
  logic [WORD_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 terr_q, terr_d;
  logic [LIM_W-1:0]     idle_q, idle_d;

  logic [CNT_W-1:0]     half_div;
  logic [PROD_W-1:0]    prod;
  logic [LIM_W-1:0]     idle_lim;
  logic [LIM_W:0]       idle_nxt;

  uart_autobaud_meter #(
    .CNT_W   (CNT_W),
    .MIN_DIV (MIN_DIV)
  ) u_meter (
    .clock_i  (clock),
    .reset_i  (reset),
    .rx_i     (rx),
    .rearm_i  (rearm),
    .rxs_o    (rxs),
    .fall_o   (rxs_fall),
    .locked_o (baud_locked),
    .div_o    (baud_div)
  );

  assign half_div = baud_div >> 1;
  // Idle limit is TIMEOUT_BITS bit-times, clamped to the idle counter range.
  assign prod     = PROD_W'(baud_div) * PROD_W'(TIMEOUT_BITS);
  assign idle_lim = (prod[PROD_W-1:LIM_W] != '0) ? '1 : prod[LIM_W-1:0];
  assign idle_nxt = {1'b0, idle_q} + (LIM_W+1)'(1);

  assign word_data   = data_q;
  assign word_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign timeout_err = terr_q;

  // Receive state, assembly buffer and output holding registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      terr_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      terr_q  <= terr_d;
      idle_q  <= idle_d;
    end
  end

  // Bit timing, byte commit, word completion, handshake and idle timeout.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    terr_d  = 1'b0;
    idle_d  = '0;

    if (valid_q && word_ready) valid_d = 1'b0;

    if (rearm) begin
      state_d = RX_IDLE;
      tmr_d   = '0;
      bit_d   = '0;
      idx_d   = '0;
      asm_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (baud_locked && rxs_fall) begin
            tmr_d   = CNT_W'(1);
            state_d = RX_START;
          end else if (idx_q != '0) begin
            if (idle_nxt >= {1'b0, idle_lim}) begin
              idx_d  = '0;
              terr_d = 1'b1;
            end else begin
              idle_d = idle_nxt[LIM_W-1:0];
            end
          end
        end
        RX_START: begin
          if (tmr_q >= half_div) begin
            tmr_d   = CNT_W'(1);
            bit_d   = '0;
            state_d = rxs ? RX_IDLE : RX_DATA;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (tmr_q >= baud_div) begin
            tmr_d = CNT_W'(1);
            sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
            if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = RX_STOP;
            else                                bit_d   = bit_q + BIT_W'(1);
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (tmr_q >= baud_div) begin
            if (rxs) begin
              state_d = RX_IDLE;
              // First byte of a word lands in the top slot.
              for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                if (32'(idx_q) + b == WORD_BYTES - 1) asm_d[DATA_BITS*b +: DATA_BITS] = sh_q;
              end
              if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
                idx_d = '0;
                if (!valid_q || word_ready) begin
                  data_d  = asm_d;
                  valid_d = 1'b1;
                end else begin
                  oerr_d = 1'b1;
                end
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else begin
              ferr_d  = 1'b1;
              idx_d   = '0;
              state_d = RX_WAIT_HIGH;
            end
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_autobaud_word_rx.sv
// Bench for uart_autobaud_word_rx: serial driver, word monitor and a byte-to-word model.
module tb_uart_autobaud_word_rx;

  localparam int unsigned WB = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned MD = 16;
  localparam int unsigned TB = 32;
  localparam int          P1 = 40;
  localparam int          P2 = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx    = 1'b1;
  logic          rearm = 1'b0;
  logic          word_ready;
  logic          baud_locked;
  logic [CW-1:0] baud_div;
  logic [31:0]   word_data;
  logic          word_valid;
  logic          frame_err, overrun_err, timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int   ready_mode = 1;   // 0 low, 1 high, 2 random
  logic rnd_bit    = 1'b1;

  // Monitor-owned records.
  logic [31:0] got_q[$];
  int fe_cnt = 0, oe_cnt = 0, to_cnt = 0;

  // Model-owned expectations.
  logic [31:0] exp_q[$];
  int got_rd = 0;
  int exp_fe = 0, exp_oe = 0, exp_to = 0;

  typedef struct packed {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] gap;
    logic [31:0] exp_word;
  } vec_t;
  vec_t tbl[8];

  uart_autobaud_word_rx #(
    .WORD_BYTES   (WB),
    .CNT_W        (CW),
    .MIN_DIV      (MD),
    .TIMEOUT_BITS (TB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .rearm       (rearm),
    .baud_locked (baud_locked),
    .baud_div    (baud_div),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  assign word_ready = (ready_mode == 1) || ((ready_mode == 2) && rnd_bit);

  always @(posedge clock) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (word_valid && word_ready) got_q.push_back(word_data);
      if (frame_err)   fe_cnt++;
      if (overrun_err) oe_cnt++;
      if (timeout_err) to_cnt++;
    end
  end

  function automatic logic [31:0] pack4(input int b0, input int b1, input int b2, input int b3);
    longint w;
    w = ((longint'(b0) * 256 + b1) * 256 + b2) * 256 + b3;
    return 32'(w);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    cyc(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input int p, input logic stop_ok, input int gap);
    line(1'b0, p);
    for (int i = 0; i < 8; i++) line(b[i], p);
    line(stop_ok, p);
    if (!stop_ok) line(1'b1, p);
    line(1'b1, gap);
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input int p, input int gap);
    send_byte(b0, p, 1'b1, gap);
    send_byte(b1, p, 1'b1, gap);
    send_byte(b2, p, 1'b1, gap);
    send_byte(b3, p, 1'b1, gap);
  endtask

  task automatic check_words(input string name);
    int avail;
    int n;
    cyc(40);
    avail = got_q.size() - got_rd;
    check({name, " count"}, 64'(avail), 64'(exp_q.size()));
    n = (avail < exp_q.size()) ? avail : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check(name, got_q[got_rd], exp_q[0]);
      got_rd++;
      void'(exp_q.pop_front());
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic check_errs(input string name);
    check({name, " frame_err pulses"},   64'(fe_cnt), 64'(exp_fe));
    check({name, " overrun_err pulses"}, 64'(oe_cnt), 64'(exp_oe));
    check({name, " timeout_err pulses"}, 64'(to_cnt), 64'(exp_to));
  endtask

  task automatic check_lock(input string name, input int p);
    check({name, " locked"}, 64'(baud_locked), 64'd1);
    check({name, " div window"}, 64'((int'(baud_div) >= p - 2) && (int'(baud_div) <= p + 2)), 64'd1);
  endtask

  initial begin
    logic [7:0] rb[4];
    int gap;

    tbl[0] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h13, gap: 16'd0,  exp_word: 32'h00000013};
    tbl[1] = '{b0: 8'h20, b1: 8'h00, b2: 8'h01, b3: 8'h37, gap: 16'd40, exp_word: 32'h20000137};
    tbl[2] = '{b0: 8'h00, b1: 8'hc0, b2: 8'h00, b3: 8'hef, gap: 16'd5,  exp_word: 32'h00c000ef};
    tbl[3] = '{b0: 8'h00, b1: 8'ha0, b2: 8'h05, b3: 8'h13, gap: 16'd80, exp_word: 32'h00a00513};
    tbl[4] = '{b0: 8'h00, b1: 8'hb5, b2: 8'h05, b3: 8'h33, gap: 16'd1,  exp_word: 32'h00b50533};
    tbl[5] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h93, gap: 16'd17, exp_word: 32'h00000093};
    tbl[6] = '{b0: 8'hfe, b1: 8'h05, b2: 8'h1e, b3: 8'he3, gap: 16'd0,  exp_word: 32'hfe051ee3};
    tbl[7] = '{b0: 8'hff, b1: 8'h9f, b2: 8'hf0, b3: 8'h6f, gap: 16'd120, exp_word: 32'hff9ff06f};

    // Reset state
    reset = 1'b1;
    @(posedge clock); #1;
    check("reset baud_locked", 64'(baud_locked), 64'd0);
    check("reset baud_div",    64'(baud_div),    64'd0);
    check("reset word_valid",  64'(word_valid),  64'd0);
    check("reset word_data",   64'(word_data),   64'd0);
    check("reset err pulses",  64'({frame_err, overrun_err, timeout_err}), 64'd0);
    cyc(2);
    reset = 1'b0;
    cyc(4);

    // Short glitch and an over-long low must both leave the link unlocked
    line(1'b0, 5);
    line(1'b1, 20);
    check("glitch baud_locked", 64'(baud_locked), 64'd0);
    line(1'b0, 300);
    line(1'b1, 20);
    check("saturate baud_locked", 64'(baud_locked), 64'd0);
    check("saturate baud_div",    64'(baud_div),    64'd0);

    // Lock on 0xFF: lock is visible right after the start bit
    line(1'b0, P1);
    line(1'b1, 4);
    check_lock("sync1", P1);
    line(1'b1, 9 * P1);
    check_errs("after lock");

    // Program words from the table, ready held high
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send4(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, P1, int'(tbl[i].gap));
      exp_q.push_back(tbl[i].exp_word);
    end
    check_words("program word");

    // Random bytes, random gaps, random ready
    ready_mode = 2;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
      gap = $urandom_range(0, 3 * P1);
      send4(rb[0], rb[1], rb[2], rb[3], P1, gap);
      exp_q.push_back(pack4(rb[0], rb[1], rb[2], rb[3]));
    end
    check_words("random word");
    check_errs("random");

    // Backpressure: second word is dropped, first is held unchanged
    ready_mode = 0;
    cyc(4);
    send4(8'hCA, 8'hFE, 8'hBA, 8'hBE, P1, P1);
    check("held valid", 64'(word_valid), 64'd1);
    check("held data",  64'(word_data),  64'hCAFEBABE);
    send_byte(8'h12, P1, 1'b1, P1);
    check("held data mid", 64'(word_data), 64'hCAFEBABE);
    send_byte(8'h34, P1, 1'b1, P1);
    send_byte(8'h56, P1, 1'b1, P1);
    send_byte(8'h78, P1, 1'b1, P1);
    exp_oe++;
    check("overrun held data",  64'(word_data),  64'hCAFEBABE);
    check("overrun held valid", 64'(word_valid), 64'd1);
    exp_q.push_back(32'hCAFEBABE);
    ready_mode = 1;
    cyc(3);
    check("valid after drain", 64'(word_valid), 64'd0);
    check_words("drained word");
    check_errs("overrun");

    // Framing error drops the bad byte and any partial word
    send_byte(8'hA5, P1, 1'b0, P1);
    exp_fe++;
    send4(8'h11, 8'h22, 8'h33, 8'h44, P1, P1);
    exp_q.push_back(32'h11223344);
    check_words("post-frame word");
    check_errs("frame");

    // Timeout discards a two-byte partial word
    send_byte(8'hAA, P1, 1'b1, P1);
    send_byte(8'hBB, P1, 1'b1, P1);
    line(1'b1, 40 * P1);
    exp_to++;
    check_errs("timeout");
    send4(8'h01, 8'h02, 8'h03, 8'h04, P1, P1);
    exp_q.push_back(32'h01020304);
    check_words("post-timeout word");

    // Rearm mid-byte with a held word, then relock at a new rate
    ready_mode = 0;
    send4(8'hDE, 8'hAD, 8'hBE, 8'hEF, P1, P1);
    check("pre-rearm valid", 64'(word_valid), 64'd1);
    line(1'b0, P1);
    line(1'b1, 2 * P1);
    rearm = 1'b1;
    cyc(1);
    rearm = 1'b0;
    cyc(2);
    check("rearm baud_locked", 64'(baud_locked), 64'd0);
    check("rearm baud_div",    64'(baud_div),    64'd0);
    check("rearm word_valid",  64'(word_valid),  64'd0);
    check("rearm word_data",   64'(word_data),   64'd0);
    line(1'b1, 10 * P1);
    ready_mode = 1;
    send_byte(8'hFF, P2, 1'b1, P2);
    check_lock("sync2", P2);
    send4(8'h0B, 8'hAD, 8'hF0, 8'h0D, P2, P2);
    exp_q.push_back(32'h0BADF00D);
    check_words("relock word");
    check_errs("rearm");

    // Asynchronous reset in the middle of a word
    send_byte(8'h55, P2, 1'b1, P2);
    send_byte(8'h66, P2, 1'b1, P2);
    line(1'b0, P2);
    line(1'b1, P2);
    #3 reset = 1'b1;
    #1;
    check("async reset baud_locked", 64'(baud_locked), 64'd0);
    check("async reset baud_div",    64'(baud_div),    64'd0);
    check("async reset word_valid",  64'(word_valid),  64'd0);
    check("async reset word_data",   64'(word_data),   64'd0);
    check("async reset err pulses",  64'({frame_err, overrun_err, timeout_err}), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    cyc(5);
    check("post-reset word count", 64'(got_q.size() - got_rd), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_autobaud_word_rx.md
Name: uart_autobaud_word_rx

Overview:
- Parametrised successor to the single-byte boot UART path.
- Locks the bit period from the 0xFF auto-baud sync byte, then receives 8N1 bytes.
- Assembles bytes big-endian into WORD_BYTES-wide words: the first byte received lands in the MSB, matching the host's send_word order.
- Sits between the rx pad and the boot loader / instruction-memory writer. Words are presented on a valid/ready handshake, with framing, overrun and timeout handling.

Parameters:
- WORD_BYTES, 4, bytes per output word (1..8).
- CNT_W, 20, width of the bit-period counter; the maximum measurable period is 2^CNT_W-1 cycles.
- MIN_DIV, 16, smallest accepted bit period in cycles; shorter lows are treated as glitches.
- TIMEOUT_BITS, 32, idle bit-times after which a partial word is discarded.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  raw serial line from the pad; idles high; asynchronous to clock.
- rearm  in  1  single-cycle pulse: drop lock and partial/held data, return to calibration.
- baud_locked  out  1  high once a valid sync byte has been measured.
- baud_div  out  CNT_W  measured bit period in clock cycles.
- word_data  out  8*WORD_BYTES  assembled word; stable while word_valid is high.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accepts; a transfer occurs on the cycle word_valid&&word_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: a word completed while the previous one was still held.
- timeout_err  out  1  one-cycle pulse: a partial word was discarded by timeout.

Behaviour:
- Clocking and reset:
  - Single clock domain, named clock.
  - reset is asynchronous and active-high. On assertion all outputs go to 0 and baud_div goes to 0.
  - The FSM enters CAL_IDLE, the byte index goes to 0, and the synchroniser flops are set to 1.
- rx is passed through a 2-flop synchroniser set to 1 on reset. All timing below refers to the synchronised signal rxs, which lags the pad by 2 cycles.
- Calibration FSM:
  - CAL_IDLE: on a falling edge of rxs, clear the counter and go to CAL_MEAS.
  - CAL_MEAS: increment the counter each cycle while rxs is 0. On the rising edge:
    - count >= MIN_DIV: load baud_div=count, set baud_locked=1, go to RX_IDLE.
    - count < MIN_DIV: return to CAL_IDLE.
    - Counter saturates at all-ones while rxs is still low: return to CAL_IDLE when rxs rises, with baud_locked left at 0.
  - The remaining bits of 0xFF are high, so no further edges occur during the sync byte.
- Receive FSM:
  - RX_IDLE: a falling edge of rxs goes to RX_START.
  - RX_START: wait baud_div/2 cycles (floor), then sample. If sampled 0, go to RX_DATA. If sampled 1, it is a false start: go back to RX_IDLE with no error.
  - RX_DATA: 8 samples, each exactly baud_div cycles after the previous one, LSB first, into a shift register.
  - RX_STOP: wait baud_div cycles, then sample.
    - Sample = 1: the byte is committed.
    - Sample = 0: pulse frame_err, discard the byte, reset the byte index to 0 (the partial word is lost), go to RX_WAIT_HIGH.
  - RX_WAIT_HIGH: wait for rxs=1, then go to RX_IDLE.
- Word assembly:
  - A committed byte is written to slot (WORD_BYTES-1-index), so byte 0 goes to bits [8*WORD_BYTES-1 -: 8]; then the index is incremented.
  - When the index reaches WORD_BYTES, the word completes and the index returns to 0.
    - word_valid=0: the word is copied to word_data and word_valid rises the cycle after the final stop-bit sample.
    - word_valid=1 and no handshake in that same cycle: the new word is dropped, overrun_err pulses, and the held word is unchanged.
    - Handshake in the same cycle as completion: the new word is loaded and word_valid stays 1.
- Handshake rules:
  - word_valid deasserts the cycle after valid&&ready, unless a new word loads in that same cycle.
  - word_data must not change while word_valid=1 and ready=0.
- Timeout:
  - In RX_IDLE with index != 0, count idle cycles. Reaching TIMEOUT_BITS*baud_div discards the partial word, resets the index to 0 and pulses timeout_err.
  - Any falling edge clears the idle count.
  - The product is computed at CNT_W+6 bits and saturates.
- rearm:
  - Highest priority after reset, in any state.
  - Clears baud_locked, baud_div, the index, word_valid and word_data, then goes to CAL_IDLE.
  - A byte in flight is abandoned without an error pulse.
- Simultaneous events: reset overrides rearm; rearm overrides completion, handshake and timeout.

Decomposition:
- Shared package uart_pkg holds:
  - cal_state_t: CAL_IDLE, CAL_MEAS.
  - rx_state_t: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH.
  - SYNC_BYTE=8'hFF.
  - DATA_BITS=8.
- One natural sub-module, uart_autobaud_meter: synchroniser, edge detect, calibration FSM, baud_div/baud_locked. The top holds the receive FSM, word assembly and handshake.

Test Plan:
- Lock: 10 ns clock, send 0xFF at 9600 baud -> baud_locked=1 and baud_div within 10416±2 after the sync start bit ends; no error pulses.
- Word: after lock, send bytes 0x00,0x00,0x00,0x13 with word_ready=1 -> one word_valid pulse with word_data=32'h00000013. The 8-word program sequence 0x00000013, 0x20000137, ... 0xff9ff06f arrives in order.
- Backpressure/overrun: word_ready=0, send 2 words 0xCAFEBABE then 0x12345678 -> word_data stays 0xCAFEBABE and overrun_err pulses once. Raising ready transfers 0xCAFEBABE, then word_valid=0.
- Framing: send byte 0xA5 with stop bit forced 0, then 4 good bytes 0x11223344 -> one frame_err pulse; next word is 0x11223344, not a mix with 0xA5.
- Glitch/timeout: a 5-cycle low pulse in CAL_IDLE -> baud_locked stays 0. After lock, send 2 bytes and idle 40 bit-times -> timeout_err pulses and the index resets; the next 4 bytes form a clean word.
- Rearm/reset: assert rearm mid-byte -> baud_locked=0, word_valid=0, and re-lock succeeds at 115200 baud (baud_div≈868). Assert reset mid-word -> all outputs 0 asynchronously.
